fifo_rr_drain: RTL and testbench

- Round-robin scheduler that drains N show-ahead synchronous FIFOs into one registered output stream.
- Source FIFOs use the team's standard interface: head data valid while not empty, pop strobe.
- Grants are given in bursts of up to MAX_BURST words per source.
- Sits between per-channel FIFOs and a shared downstream consumer, e.g. a bus master or serializer.

---
 rtl/fifo_rr_drain.sv | 88 ++++++++
 tb/tb_fifo_rr_drain.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_drain.sv
// fifo_rr_drain: round-robin burst drain of N show-ahead FIFOs into one registered output stream.
// Optional macro FIFO_RR_DRAIN_PRIO0_EN: source 0 wins every arbitration in which it is non-empty.
module fifo_rr_drain #(
    parameter int N         = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_empty,
    output logic [N-1:0]         in_rd,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_src,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int SW = $clog2(N);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    typedef enum logic {ARB, BURST} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] g, sel;
    logic [CW-1:0] cnt;
    logic          any, pop, burst_end;

    // Circular scan from g+1; the lowest offset that is non-empty wins, g itself is checked last
    always_comb begin
        sel = g;
        any = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (!in_empty[(int'(g) + i) % N]) begin
                sel = SW'((int'(g) + i) % N);
                any = 1'b1;
            end
        end
`ifdef FIFO_RR_DRAIN_PRIO0_EN
        if (!in_empty[0]) sel = '0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB;
        else        state <= state_nxt;
    end

    // Next state: grant when anything is pending, leave a burst when the source empties or the burst is full
    always_comb begin
        state_nxt = (state == ARB) ? (any ? BURST : ARB) : ((in_empty[g] || burst_end) ? ARB : BURST);
    end

    // Outputs: pop the granted source only while bursting and the output slot is free
    always_comb begin
        pop       = (state == BURST) && !in_empty[g] && (!out_valid || out_ready);
        burst_end = pop && (cnt == LAST_CNT);
        in_rd     = pop ? ({{(N-1){1'b0}}, 1'b1} << g) : '0;
    end

    // Grant index, burst counter and the registered output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g         <= SW'(N - 1);
            cnt       <= '0;
            out_data  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (state == ARB && any) begin
                g   <= sel;
                cnt <= '0;
            end
            if (pop) begin
                out_data  <= in_data[g*WIDTH +: WIDTH];
                out_src   <= g;
                out_valid <= 1'b1;
                out_last  <= (cnt == LAST_CNT);
                cnt       <= cnt + CW'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rr_drain.sv
// tb_fifo_rr_drain: randomized and directed scoreboard bench for fifo_rr_drain (N=4, WIDTH=16, MAX_BURST=4).
module tb_fifo_rr_drain;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MB = 4;

    typedef struct packed {
        logic [1:0]   src;
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_empty = '1;
    logic [N-1:0]   in_rd;
    logic [N-1:0]   mask = '0;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_last;
    logic           out_valid;
    logic           out_ready = 1'b1;

    logic [W-1:0] src_q[N][$];
    logic [W-1:0] exp_q[N][$];
    exp_t         ord_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int first_cyc = -1;
    int last_cyc = 0;

    logic         stall_prev = 1'b0;
    logic [W-1:0] held_data;
    logic [1:0]   held_src;
    logic         held_last;

    fifo_rr_drain #(.N(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_empty(in_empty),
        .in_rd(in_rd),
        .out_data(out_data),
        .out_src(out_src),
        .out_last(out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic push(input int s, input logic [W-1:0] d);
        src_q[s].push_back(d);
        exp_q[s].push_back(d);
    endtask

    task automatic expect_word(input int s, input int d, input logic l);
        exp_t e;
        e.src  = 2'(s);
        e.data = W'(d);
        e.last = l;
        ord_q.push_back(e);
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            exp_q[k].delete();
        end
        ord_q.delete();
    endtask

    function automatic int pending();
        int t = 0;
        for (int k = 0; k < N; k++) t += exp_q[k].size();
        return t;
    endfunction

    task automatic drain(input int budget, input string nm);
        int n = 0;
        while ((ord_q.size() != 0 || pending() != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, "_drain_left"}, 32'(ord_q.size() + pending()), 32'd0);
    endtask

    // Source FIFO side: consume heads on pops and check every pop is legal
    always @(posedge clk) begin
        cyc++;
        if (in_rd != '0) begin
            chk("rd_onehot", 32'($onehot(in_rd)), 32'd1);
            chk("rd_stalled", 32'(out_valid && !out_ready), 32'd0);
            for (int k = 0; k < N; k++) begin
                if (in_rd[k]) begin
                    chk("rd_empty", 32'(in_empty[k]), 32'd0);
                    if (src_q[k].size() != 0) void'(src_q[k].pop_front());
                end
            end
        end
    end

    // Monitor: compare accepted words against the scoreboard, then present the new FIFO heads
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev)
                chk("hold", 32'({out_valid, out_src, out_data, out_last}), 32'({1'b1, held_src, held_data, held_last}));
            if (out_valid && out_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (exp_q[out_src].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word: got src %0d data %0h expected none", out_src, out_data);
                end else begin
                    chk("src_data", 32'(out_data), 32'(exp_q[out_src].pop_front()));
                end
                if (ord_q.size() != 0)
                    chk("order", 32'({out_src, out_data, out_last}), 32'(ord_q.pop_front()));
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_src   = out_src;
            held_last  = out_last;
        end else begin
            stall_prev = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            in_empty[k]        = (src_q[k].size() == 0) || mask[k];
            in_data[k*W +: W]  = (src_q[k].size() != 0) ? src_q[k][0] : '0;
        end
    end

    initial begin
        int bo[8];
        int used[N];
        int n;
        int s;

        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_rd", 32'(in_rd), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (20) begin
            @(negedge clk);
            #1;
            chk("idle", 32'({out_valid, in_rd}), 32'd0);
        end

        // Four fully loaded sources: bursts of four with one bubble between bursts
`ifdef FIFO_RR_DRAIN_PRIO0_EN
        bo = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
        bo = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            used[k] = 0;
            for (int i = 0; i < 8; i++) push(k, W'(k * 256 + i));
        end
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < MB; j++) expect_word(bo[b], bo[b] * 256 + used[bo[b]] * MB + j, j == MB - 1);
            used[bo[b]]++;
        end
        first_cyc = -1;
        drain(200, "full");
        chk("full_span", 32'(last_cyc - first_cyc), 32'd38);

        // Short source: burst ends on empty without a last flag, then the block idles
        @(posedge clk);
        #1;
        push(2, 16'h0220);
        push(2, 16'h0221);
        expect_word(2, 16'h0220, 1'b0);
        expect_word(2, 16'h0221, 1'b0);
        drain(50, "short");
        repeat (20) begin
            @(negedge clk);
            #1;
            chk("short_idle", 32'({out_valid, in_rd}), 32'd0);
        end

        // Back-pressure toggling every cycle on a single source
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            push(1, W'(16'h0150 + i));
            expect_word(1, 16'h0150 + i, (i % MB) == MB - 1);
        end
        n = 0;
        while (ord_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            out_ready = ~out_ready;
            n++;
        end
        out_ready = 1'b1;
        drain(50, "toggle");

        // Reset while the second word of a burst is on the output
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) push(2, W'(16'h0200 + i));
        n = 0;
        while (!(out_valid && out_data == 16'h0201) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rst_wait", 32'(n < 50), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_rd", 32'(in_rd), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        clear_all();
        push(3, 16'h0300);
        push(3, 16'h0301);
        push(1, 16'h0100);
        push(1, 16'h0101);
        expect_word(1, 16'h0100, 1'b0);
        expect_word(1, 16'h0101, 1'b0);
        expect_word(3, 16'h0300, 1'b0);
        expect_word(3, 16'h0301, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain(60, "postrst");

        // Random traffic, random empties and random back-pressure
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(3) != 0);
            mask = ($urandom_range(3) == 0) ? N'($urandom) : '0;
            if ($urandom_range(1) == 1) begin
                s = int'($urandom_range(N - 1));
                if (src_q[s].size() < 12) push(s, W'($urandom));
            end
        end
        @(posedge clk);
        #1;
        mask = '0;
        out_ready = 1'b1;
        drain(800, "rand");

        // Two continuously busy sources after a fresh reset
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_all();
        for (int i = 0; i < 16; i++) begin
            push(0, W'(i));
            push(1, W'(256 + i));
        end
`ifdef FIFO_RR_DRAIN_PRIO0_EN
        for (int w = 0; w < 32; w++) expect_word(w / 16, (w / 16) * 256 + (w % 16), (w % MB) == MB - 1);
`else
        for (int w = 0; w < 32; w++) expect_word((w / MB) % 2, ((w / MB) % 2) * 256 + (w / (2 * MB)) * MB + (w % MB), (w % MB) == MB - 1);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain(200, "two_src");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
